// File: rtl/cpu_pcstack_if.sv
// Control, bus and status signals of the PC / return-address stack.
// The master drives the operation strobes and data; the slave (the stack) returns PC, level and flags.
interface cpu_pcstack_if #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              INC_I;
    logic              LDL_I;
    logic              LDH_I;
    logic              PUSH_I;
    logic              POP_I;
    logic              RSTV_I;
    logic [2:0]        VEC_I;
    logic              BSEL_I;
    logic              FCLR_I;
    logic [7:0]        DAT_I;
    logic [7:0]        DAT_O;
    logic [ADDR_W-1:0] PC_O;
    logic [LVL_W-1:0]  LVL_O;
    logic              OVF_O;
    logic              UDF_O;

    modport master (
        output INC_I, LDL_I, LDH_I, PUSH_I, POP_I, RSTV_I, VEC_I, BSEL_I, FCLR_I, DAT_I,
        input  DAT_O, PC_O, LVL_O, OVF_O, UDF_O
    );

    modport slave (
        input  INC_I, LDL_I, LDH_I, PUSH_I, POP_I, RSTV_I, VEC_I, BSEL_I, FCLR_I, DAT_I,
        output DAT_O, PC_O, LVL_O, OVF_O, UDF_O
    );
endinterface

// File: rtl/cpu_pcstack.sv
// Program counter plus return-address stack with byte loads, call/return and restart vectors.
// One-cycle latency on PC/level/flags; no backpressure, an operation is accepted every cycle.
module cpu_pcstack #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 8,
    parameter bit WRAP   = 1'b1
) (
    input logic           CLK_I,
    input logic           RST_I,
    cpu_pcstack_if.slave  bus
);
    localparam int SP_W  = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic [ADDR_W-1:0] pc_cur;
    logic [ADDR_W-1:0] vec_pc;
    logic [SP_W-1:0]   sp_up, sp_dn;
    logic              full, empty;
    logic              push_req, pop_req, pp_both;
    logic [15:0]       pc_ext;
    logic              unused_dat;

    assign pc_cur   = mem_q[sp_q];
    assign vec_pc   = {{(ADDR_W-6){1'b0}}, bus.VEC_I, 3'b000};
    assign sp_up    = sp_q + SP_W'(1);
    assign sp_dn    = sp_q - SP_W'(1);
    assign full     = (lvl_q == LVL_W'(DEPTH-1));
    assign empty    = (lvl_q == '0);
    // Restart outranks call/return; a simultaneous call and return cancel out.
    assign push_req = bus.RSTV_I | (bus.PUSH_I & ~bus.POP_I);
    assign pop_req  = ~bus.RSTV_I & bus.POP_I & ~bus.PUSH_I;
    assign pp_both  = ~bus.RSTV_I & bus.PUSH_I & bus.POP_I;

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        lvl_d = lvl_q;
        ovf_d = ovf_q & ~bus.FCLR_I;
        udf_d = udf_q & ~bus.FCLR_I;

        if (push_req) begin
            if (full) ovf_d = 1'b1;
            if (!full || WRAP) begin
                mem_d[sp_up] = bus.RSTV_I ? vec_pc : pc_cur;
                sp_d         = sp_up;
                if (!full) lvl_d = lvl_q + LVL_W'(1);
            end
        end else if (pop_req) begin
            if (empty) udf_d = 1'b1;
            if (!empty || WRAP) begin
                sp_d = sp_dn;
                if (!empty) lvl_d = lvl_q - LVL_W'(1);
            end
        end else if (!pp_both) begin
            if (bus.LDL_I || bus.LDH_I) begin
                if (bus.LDL_I) mem_d[sp_q][7:0]        = bus.DAT_I;
                if (bus.LDH_I) mem_d[sp_q][ADDR_W-1:8] = bus.DAT_I[ADDR_W-9:0];
            end else if (bus.INC_I) begin
                mem_d[sp_q] = pc_cur + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mem_q <= '{default: '0};
            sp_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            sp_q  <= sp_d;
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign pc_ext     = 16'(pc_cur);
    assign bus.DAT_O  = bus.BSEL_I ? pc_ext[15:8] : pc_ext[7:0];
    assign bus.PC_O   = pc_cur;
    assign bus.LVL_O  = lvl_q;
    assign bus.OVF_O  = ovf_q;
    assign bus.UDF_O  = udf_q;
    // Upper DAT_I bits are dropped on high-byte loads for narrow PCs.
    assign unused_dat = ^bus.DAT_I;
endmodule

// File: tb/tb_cpu_pcstack.sv
// Directed bench: one wrapping stack and one guarded stack, both 8 x 14 bits.
module tb_cpu_pcstack;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cpu_pcstack_if #(.ADDR_W(14), .DEPTH(8)) a_if ();
    cpu_pcstack_if #(.ADDR_W(14), .DEPTH(8)) b_if ();

    cpu_pcstack #(.ADDR_W(14), .DEPTH(8), .WRAP(1'b1)) u_wrap  (.CLK_I(clk), .RST_I(rst), .bus(a_if.slave));
    cpu_pcstack #(.ADDR_W(14), .DEPTH(8), .WRAP(1'b0)) u_guard (.CLK_I(clk), .RST_I(rst), .bus(b_if.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_if.INC_I = 0; a_if.LDL_I = 0; a_if.LDH_I = 0; a_if.PUSH_I = 0; a_if.POP_I = 0;
        a_if.RSTV_I = 0; a_if.VEC_I = 0; a_if.FCLR_I = 0; a_if.DAT_I = 0;
        b_if.INC_I = 0; b_if.LDL_I = 0; b_if.LDH_I = 0; b_if.PUSH_I = 0; b_if.POP_I = 0;
        b_if.RSTV_I = 0; b_if.VEC_I = 0; b_if.FCLR_I = 0; b_if.DAT_I = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int pc, input int lvl, input int ovf, input int udf);
        chk({tag, ".pc"},  32'(a_if.PC_O),  32'(pc));
        chk({tag, ".lvl"}, 32'(a_if.LVL_O), 32'(lvl));
        chk({tag, ".ovf"}, 32'(a_if.OVF_O), 32'(ovf));
        chk({tag, ".udf"}, 32'(a_if.UDF_O), 32'(udf));
    endtask

    task automatic chk_b(input string tag, input int pc, input int lvl, input int ovf, input int udf);
        chk({tag, ".pc"},  32'(b_if.PC_O),  32'(pc));
        chk({tag, ".lvl"}, 32'(b_if.LVL_O), 32'(lvl));
        chk({tag, ".ovf"}, 32'(b_if.OVF_O), 32'(ovf));
        chk({tag, ".udf"}, 32'(b_if.UDF_O), 32'(udf));
    endtask

    initial begin
        idle();
        a_if.BSEL_I = 0; b_if.BSEL_I = 0;
        rst = 1; tick(); tick(); rst = 0;
        chk_a("rst_a", 0, 0, 0, 0);
        chk_b("rst_b", 0, 0, 0, 0);
        chk("rst_datl", 32'(a_if.DAT_O), 32'h0);
        a_if.BSEL_I = 1; #1;
        chk("rst_dath", 32'(a_if.DAT_O), 32'h0);
        a_if.BSEL_I = 0;

        // Byte loads, INC ignored while loading, high-byte truncation
        a_if.LDL_I = 1; a_if.INC_I = 1; a_if.DAT_I = 8'h34; tick(); idle();
        chk_a("t1_ldl", 'h0034, 0, 0, 0);
        a_if.LDH_I = 1; a_if.DAT_I = 8'hF2; tick(); idle();
        chk_a("t1_ldh", 'h3234, 0, 0, 0);
        a_if.INC_I = 1; tick(); idle();
        chk_a("t1_inc", 'h3235, 0, 0, 0);
        a_if.BSEL_I = 1; #1;
        chk("t1_dath", 32'(a_if.DAT_O), 32'h32);
        a_if.BSEL_I = 0; #1;
        chk("t1_datl", 32'(a_if.DAT_O), 32'h35);

        // Both bytes at once, then INC wrap
        a_if.LDL_I = 1; a_if.LDH_I = 1; a_if.DAT_I = 8'hFF; tick(); idle();
        chk_a("t2_ld", 'h3FFF, 0, 0, 0);
        a_if.INC_I = 1; tick(); idle();
        chk_a("t2_wrap", 'h0000, 0, 0, 0);

        // Call / return
        a_if.LDH_I = 1; a_if.DAT_I = 8'h01; tick(); idle();
        chk_a("t3_pc", 'h0100, 0, 0, 0);
        a_if.PUSH_I = 1; tick(); idle();
        chk_a("t3_push", 'h0100, 1, 0, 0);
        a_if.LDL_I = 1; a_if.DAT_I = 8'h00; tick(); idle();
        a_if.LDH_I = 1; a_if.DAT_I = 8'h20; tick(); idle();
        chk_a("t3_tgt", 'h2000, 1, 0, 0);
        a_if.BSEL_I = 1; #1;
        chk("t3_dath", 32'(a_if.DAT_O), 32'h20);
        a_if.BSEL_I = 0;
        a_if.INC_I = 1; tick(); idle();
        chk_a("t3_inc", 'h2001, 1, 0, 0);
        a_if.POP_I = 1; tick(); idle();
        chk_a("t3_pop", 'h0100, 0, 0, 0);

        // Wrapping overflow and underflow
        for (int i = 0; i < 8; i++) begin
            a_if.LDH_I = 1; a_if.DAT_I = 8'h10; tick(); idle();
            a_if.LDL_I = 1; a_if.DAT_I = 8'(i); tick(); idle();
            a_if.PUSH_I = 1; tick(); idle();
            if (i == 6) chk_a("t4_full", 'h1006, 7, 0, 0);
        end
        chk_a("t4_ovf", 'h1007, 7, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            a_if.POP_I = 1; tick(); idle();
            chk_a($sformatf("t4_pop%0d", k), 'h1008 - k, 7 - k, 1, 0);
        end
        a_if.POP_I = 1; tick(); idle();
        chk_a("t4_udf", 'h1007, 0, 1, 1);
        a_if.FCLR_I = 1; tick(); idle();
        chk_a("t4_fclr", 'h1007, 0, 0, 0);

        // Guarded overflow and underflow
        for (int i = 0; i < 7; i++) begin
            b_if.LDH_I = 1; b_if.DAT_I = 8'h20; tick(); idle();
            b_if.LDL_I = 1; b_if.DAT_I = 8'(i); tick(); idle();
            b_if.PUSH_I = 1; tick(); idle();
        end
        chk_b("t5_full", 'h2006, 7, 0, 0);
        b_if.LDL_I = 1; b_if.DAT_I = 8'h07; tick(); idle();
        b_if.PUSH_I = 1; tick(); idle();
        chk_b("t5_ovf", 'h2007, 7, 1, 0);
        b_if.FCLR_I = 1; tick(); idle();
        chk_b("t5_fclr", 'h2007, 7, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            b_if.POP_I = 1; tick(); idle();
            chk_b($sformatf("t5_pop%0d", k), 'h2007 - k, 7 - k, 0, 0);
        end
        b_if.POP_I = 1; tick(); idle();
        chk_b("t5_udf", 'h2000, 0, 0, 1);
        b_if.FCLR_I = 1; tick(); idle();
        chk_b("t5_fclr2", 'h2000, 0, 0, 0);
        b_if.FCLR_I = 1; b_if.POP_I = 1; tick(); idle();
        chk_b("t5_setwins", 'h2000, 0, 0, 1);
        b_if.FCLR_I = 1; tick(); idle();
        chk_b("t5_fclr3", 'h2000, 0, 0, 0);

        // Restart priority, push+pop no-op, reset mid-sequence
        a_if.RSTV_I = 1; a_if.VEC_I = 3'd7; a_if.INC_I = 1; a_if.LDL_I = 1;
        a_if.DAT_I = 8'hAA; a_if.PUSH_I = 1; tick(); idle();
        chk_a("t6_rstv7", 'h0038, 1, 0, 0);
        a_if.RSTV_I = 1; a_if.VEC_I = 3'd5; tick(); idle();
        chk_a("t6_rstv5", 'h0028, 2, 0, 0);
        a_if.POP_I = 1; tick(); idle();
        chk_a("t6_ret1", 'h0038, 1, 0, 0);
        a_if.POP_I = 1; tick(); idle();
        chk_a("t6_ret2", 'h1007, 0, 0, 0);
        a_if.PUSH_I = 1; a_if.POP_I = 1; a_if.LDL_I = 1; a_if.DAT_I = 8'h55; tick(); idle();
        chk_a("t6_pp", 'h1007, 0, 0, 0);
        a_if.POP_I = 1; tick(); idle();
        chk_a("t6_udf", 'h1007, 0, 0, 1);
        rst = 1; a_if.RSTV_I = 1; a_if.VEC_I = 3'd3; tick(); idle(); rst = 0;
        chk_a("t6_rst", 0, 0, 0, 0);
        chk("t6_datl", 32'(a_if.DAT_O), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
